xdma_stream_demux: RTL and testbench
====================================

// Module: xdma_stream_demux
// PURPOSE
// - Routes one valid/ready stream to one of N narrow output channels (cfg, grant, finish, ...) by destination index.
// - It is the inverse of the xdma priority select: that block encodes N requests into one index; this one decodes an index into N outputs.
// - Destination is locked per packet (first beat to last beat). One registered output stage gives a 1-cycle data latency.
// - Sits between the xdma AXI adapter's inbound narrow path and the per-function consumers.
// PARAMETERS
// - N          4    number of output channels; N>=1
// - DATA_W     64   payload width in bits
// - LOG_N_INP  $clog2(N) (1 when N==1)   index width; derived, do not override
// PORTS
// - clk_i        in   1          clock; all logic on rising edge
// - rst_i        in   1          synchronous reset, active-high
// - in_valid_i   in   1          input beat valid
// - in_ready_o   out  1          input beat accepted when valid&ready
// - in_data_i    in   DATA_W     payload
// - in_idx_i     in   LOG_N_INP  destination; sampled on the first beat of a packet only
// - in_last_i    in   1          final beat of packet
// - out_valid_o  out  N          one-hot-or-zero per-channel valid
// - out_ready_i  in   N          per-channel ready
// - out_data_o   out  DATA_W     payload, shared by all channels
// - out_last_o   out  1          last flag, shared
// - err_o        out  1          1-cycle pulse: first beat carried idx >= N
// - pkt_cnt_o    out  16         count of packets delivered (last beat handshaken on any output); wraps
// BEHAVIOUR
// - Reset: state=IDLE; out_valid_o=0; out_data_o=0; out_last_o=0; err_o=0; pkt_cnt_o=0; locked dest=0.
// - Reset mid-packet aborts the packet silently. The registered beat is discarded; no err_o pulse.
// - FSM IDLE: the next accepted beat is a first beat. Its in_idx_i is checked:
//   - idx<N: latch dest, register the beat. Go to BUSY, or stay in IDLE if in_last_i.
//   - idx>=N: pulse err_o the next cycle and discard the beat. Go to DROP, or stay in IDLE if in_last_i.
// - FSM BUSY: every accepted beat goes to the latched dest; in_idx_i is ignored. On accepted last go to IDLE.
// - FSM DROP: in_ready_o=1. Beats are consumed and discarded. On accepted last go to IDLE.
// - Output register: a single slot {valid, data, last, dest}.
//   - out_valid_o[k] = slot.valid && slot.dest==k; all other bits are 0.
//   - Slot drains on out_ready_i[slot.dest].
// - in_ready_o (IDLE/BUSY) = !slot.valid || out_ready_i[slot.dest]. Full throughput of 1 beat/cycle, no bubble.
// - in_ready_o must not depend on in_valid_i, and must not depend on out_ready_i of non-dest channels.
// - Latency: accepted at edge t -> out_valid_o at t+1.
// - Once out_valid_o is asserted, data/last/dest hold stable until handshake (AXI-stream rule).
// - Simultaneous drain and fill in one cycle: the slot reloads and valid stays 1.
// - A new packet's first beat may enter while the previous last beat still sits in the slot. Its dest is latched independently of slot.dest.
// - pkt_cnt_o increments by 1 when out valid&ready&last; 16'hFFFF+1 -> 0.
// - N==1: idx ignored (always 0); err_o is never asserted.
// STRUCTURE
// - Shared package xdma_pkg gets: typedef enum logic [1:0] {DMX_IDLE, DMX_BUSY, DMX_DROP} xdma_demux_state_e.
// - Single module, no sub-modules. The output slot is inline.
// TESTING
// - N=4: one-beat packet, idx=2, data=0xA5, last=1, all readies 1.
//   -> out_valid_o=4'b0100 the next cycle, data=0xA5; pkt_cnt_o=1.
// - N=4: 4-beat packet, idx=3 on beat 0 and idx=1 on beats 1-3.
//   -> all 4 beats appear on channel 3 only, back-to-back, in_ready_o stays 1.
// - N=3: first beat idx=3, 3-beat packet.
//   -> err_o=1 for exactly 1 cycle; in_ready_o=1 for all beats; no out_valid_o; pkt_cnt_o unchanged.
// - Backpressure: dest=1 with out_ready_i[1]=0 for 5 cycles and out_ready_i[0]=1.
//   -> in_ready_o=0 and data held stable; after out_ready_i[1]=1, 1 beat per cycle.
// - Back-to-back packets: last to idx 0, then the next first beat to idx 2 in the following cycle.
//   -> no bubble; out_valid_o goes 0001 then 0100.
// - rst_i=1 during beat 2 of 4 (BUSY).
//   -> next cycle out_valid_o=0, pkt_cnt_o=0; the next beat is treated as a first beat and its idx is honoured.

Source files
------------

// File: rtl/xdma_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xdma_pkg
// Brief   : Shared xdma types, constants and index-width helper.
// Revision: 1.0  initial release
// ============================================================================
package xdma_pkg;

   typedef enum logic [1:0] {
      DMX_IDLE = 2'd0,
      DMX_BUSY = 2'd1,
      DMX_DROP = 2'd2
   } xdma_demux_state_e;

   localparam int unsigned c_pkt_cnt_w = 16;

   // A single channel still needs a 1-bit index so the port never collapses.
   function automatic int unsigned dmx_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xdma_stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module  : xdma_stream_demux_if
// Brief   : Inbound stream plus N-way outbound channel bundle for the demux.
// Revision: 1.0  initial release
// ============================================================================
interface xdma_stream_demux_if
   import xdma_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 64
);
   localparam int LOG_N_INP = dmx_idx_w(N);

   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [DATA_W-1:0]    in_data_i;
   logic [LOG_N_INP-1:0] in_idx_i;
   logic                 in_last_i;
   logic [N-1:0]         out_valid_o;
   logic [N-1:0]         out_ready_i;
   logic [DATA_W-1:0]    out_data_o;
   logic                 out_last_o;

   // Master: upstream producer and downstream consumers as seen from outside.
   modport master (
      output in_valid_i, in_data_i, in_idx_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_last_o
   );

   modport slave (
      input  in_valid_i, in_data_i, in_idx_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_last_o
   );

endinterface
`default_nettype wire

// File: rtl/xdma_stream_demux.sv
`default_nettype none
// ============================================================================
// Module  : xdma_stream_demux
// Brief   : Routes a packetised valid/ready stream to one of N channels,
//           destination locked per packet, single registered output slot.
// Revision: 1.0  initial release
// ============================================================================
module xdma_stream_demux
   import xdma_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 64
) (
   input  wire logic                   clk_i,
   input  wire logic                   rst_i,
   xdma_stream_demux_if.slave          bus,
   output logic                        err_o,
   output logic [c_pkt_cnt_w-1:0]      pkt_cnt_o
);

   localparam int LOG_N_INP = dmx_idx_w(N);
   localparam logic [LOG_N_INP:0] c_n = (LOG_N_INP+1)'(N);

   xdma_demux_state_e        r_state;
   logic [LOG_N_INP-1:0]     r_dest;
   logic                     r_slot_valid;
   logic [DATA_W-1:0]        r_slot_data;
   logic                     r_slot_last;
   logic [LOG_N_INP-1:0]     r_slot_dest;
   logic                     r_err;
   logic [c_pkt_cnt_w-1:0]   r_pkt_cnt;

   logic                     w_dest_ready;
   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_drain;
   logic                     w_idx_ok;
   logic [LOG_N_INP-1:0]     w_first_dest;

   // Only the slot's own channel may stall the input; other readies are ignored.
   always_comb begin
      w_dest_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (r_slot_dest == LOG_N_INP'(k)) begin
            w_dest_ready = bus.out_ready_i[k];
         end
      end
   end

   assign w_drain      = r_slot_valid && w_dest_ready;
   assign w_in_ready   = (r_state == DMX_DROP) || !r_slot_valid || w_dest_ready;
   assign w_accept     = bus.in_valid_i && w_in_ready;
   assign w_idx_ok     = (N == 1) ? 1'b1 : ({1'b0, bus.in_idx_i} < c_n);
   assign w_first_dest = (N == 1) ? '0 : bus.in_idx_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= DMX_IDLE;
         r_dest       <= '0;
         r_slot_valid <= 1'b0;
         r_slot_data  <= '0;
         r_slot_last  <= 1'b0;
         r_slot_dest  <= '0;
         r_err        <= 1'b0;
         r_pkt_cnt    <= '0;
      end else begin
         r_err <= 1'b0;

         if (w_drain) begin
            r_slot_valid <= 1'b0;
            if (r_slot_last) begin
               r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
         end

         // A load in the same cycle as a drain overrides the clear above.
         case (r_state)
            DMX_IDLE: begin
               if (w_accept) begin
                  if (w_idx_ok) begin
                     r_dest       <= w_first_dest;
                     r_slot_valid <= 1'b1;
                     r_slot_data  <= bus.in_data_i;
                     r_slot_last  <= bus.in_last_i;
                     r_slot_dest  <= w_first_dest;
                     r_state      <= bus.in_last_i ? DMX_IDLE : DMX_BUSY;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= bus.in_last_i ? DMX_IDLE : DMX_DROP;
                  end
               end
            end
            DMX_BUSY: begin
               if (w_accept) begin
                  r_slot_valid <= 1'b1;
                  r_slot_data  <= bus.in_data_i;
                  r_slot_last  <= bus.in_last_i;
                  r_slot_dest  <= r_dest;
                  if (bus.in_last_i) begin
                     r_state <= DMX_IDLE;
                  end
               end
            end
            DMX_DROP: begin
               if (w_accept && bus.in_last_i) begin
                  r_state <= DMX_IDLE;
               end
            end
            default: begin
               r_state <= DMX_IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_out_valid
      assign bus.out_valid_o[k] = r_slot_valid && (r_slot_dest == LOG_N_INP'(k));
   end

   assign bus.in_ready_o = w_in_ready;
   assign bus.out_data_o = r_slot_data;
   assign bus.out_last_o = r_slot_last;
   assign err_o          = r_err;
   assign pkt_cnt_o      = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xdma_stream_demux.sv
`default_nettype none
// ============================================================================
// Module  : tb_xdma_stream_demux
// Brief   : Directed self-checking bench for xdma_stream_demux (N=4 and N=3).
// Revision: 1.0  initial release
// ============================================================================
module tb_xdma_stream_demux;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic        err4, err3;
   logic [15:0] cnt4, cnt3;

   xdma_stream_demux_if #(.N(4), .DATA_W(64)) b4 ();
   xdma_stream_demux_if #(.N(3), .DATA_W(64)) b3 ();

   xdma_stream_demux #(.N(4), .DATA_W(64)) u4 (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (b4.slave),
      .err_o     (err4),
      .pkt_cnt_o (cnt4)
   );

   xdma_stream_demux #(.N(3), .DATA_W(64)) u3 (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (b3.slave),
      .err_o     (err3),
      .pkt_cnt_o (cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++; if (b4.out_valid_o !== 4'b0000) begin bad++; $display("FAIL rst_valid4: got %b want 0000", b4.out_valid_o); end
      total++; if (b4.out_data_o !== 64'h0) begin bad++; $display("FAIL rst_data4: got %0h want 0", b4.out_data_o); end
      total++; if (b4.out_last_o !== 1'b0) begin bad++; $display("FAIL rst_last4: got %b want 0", b4.out_last_o); end
      total++; if (err4 !== 1'b0) begin bad++; $display("FAIL rst_err4: got %b want 0", err4); end
      total++; if (cnt4 !== 16'd0) begin bad++; $display("FAIL rst_cnt4: got %0d want 0", cnt4); end
      total++; if (b4.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready4: got %b want 1", b4.in_ready_o); end
      total++; if (b3.out_valid_o !== 3'b000) begin bad++; $display("FAIL rst_valid3: got %b want 000", b3.out_valid_o); end
      total++; if (cnt3 !== 16'd0) begin bad++; $display("FAIL rst_cnt3: got %0d want 0", cnt3); end
   endtask

   task automatic test_single_beat;
      b4.in_valid_i = 1'b1; b4.in_idx_i = 2'd2; b4.in_data_i = 64'hA5; b4.in_last_i = 1'b1;
      tick();
      b4.in_valid_i = 1'b0;
      total++; if (b4.out_valid_o !== 4'b0100) begin bad++; $display("FAIL single_valid: got %b want 0100", b4.out_valid_o); end
      total++; if (b4.out_data_o !== 64'hA5) begin bad++; $display("FAIL single_data: got %0h want a5", b4.out_data_o); end
      total++; if (b4.out_last_o !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", b4.out_last_o); end
      tick();
      total++; if (cnt4 !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", cnt4); end
      total++; if (b4.out_valid_o !== 4'b0000) begin bad++; $display("FAIL single_drain: got %b want 0000", b4.out_valid_o); end
   endtask

   task automatic test_locked_dest;
      for (int i = 0; i < 4; i++) begin
         b4.in_valid_i = 1'b1;
         b4.in_idx_i   = (i == 0) ? 2'd3 : 2'd1;
         b4.in_data_i  = 64'h10 + 64'(i);
         b4.in_last_i  = (i == 3);
         #1;
         total++; if (b4.in_ready_o !== 1'b1) begin bad++; $display("FAIL lock_ready[%0d]: got %b want 1", i, b4.in_ready_o); end
         tick();
         total++; if (b4.out_valid_o !== 4'b1000) begin bad++; $display("FAIL lock_valid[%0d]: got %b want 1000", i, b4.out_valid_o); end
         total++; if (b4.out_data_o !== 64'h10 + 64'(i)) begin bad++; $display("FAIL lock_data[%0d]: got %0h want %0h", i, b4.out_data_o, 64'h10 + 64'(i)); end
      end
      b4.in_valid_i = 1'b0;
      tick();
      total++; if (cnt4 !== 16'd2) begin bad++; $display("FAIL lock_cnt: got %0d want 2", cnt4); end
   endtask

   task automatic test_backpressure;
      b4.out_ready_i = 4'b1101;
      b4.in_valid_i = 1'b1; b4.in_idx_i = 2'd1; b4.in_data_i = 64'h20; b4.in_last_i = 1'b0;
      tick();
      b4.in_idx_i = 2'd0; b4.in_data_i = 64'h21;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (b4.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, b4.in_ready_o); end
         total++; if (b4.out_data_o !== 64'h20) begin bad++; $display("FAIL bp_hold[%0d]: got %0h want 20", i, b4.out_data_o); end
         total++; if (b4.out_valid_o !== 4'b0010) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 0010", i, b4.out_valid_o); end
         tick();
      end
      b4.out_ready_i = 4'b1111;
      #1;
      total++; if (b4.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", b4.in_ready_o); end
      tick();
      total++; if (b4.out_data_o !== 64'h21) begin bad++; $display("FAIL bp_beat1: got %0h want 21", b4.out_data_o); end
      b4.in_data_i = 64'h22; b4.in_last_i = 1'b1;
      tick();
      b4.in_valid_i = 1'b0;
      total++; if (b4.out_data_o !== 64'h22 || b4.out_valid_o !== 4'b0010) begin bad++; $display("FAIL bp_beat2: got %0h/%b want 22/0010", b4.out_data_o, b4.out_valid_o); end
      tick();
      total++; if (cnt4 !== 16'd3) begin bad++; $display("FAIL bp_cnt: got %0d want 3", cnt4); end
   endtask

   task automatic test_back_to_back;
      b4.in_valid_i = 1'b1; b4.in_idx_i = 2'd0; b4.in_data_i = 64'h30; b4.in_last_i = 1'b1;
      tick();
      total++; if (b4.out_valid_o !== 4'b0001) begin bad++; $display("FAIL b2b_first: got %b want 0001", b4.out_valid_o); end
      b4.in_idx_i = 2'd2; b4.in_data_i = 64'h31;
      #1;
      total++; if (b4.in_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", b4.in_ready_o); end
      tick();
      b4.in_valid_i = 1'b0;
      total++; if (b4.out_valid_o !== 4'b0100 || b4.out_data_o !== 64'h31) begin bad++; $display("FAIL b2b_second: got %b/%0h want 0100/31", b4.out_valid_o, b4.out_data_o); end
      total++; if (cnt4 !== 16'd4) begin bad++; $display("FAIL b2b_cnt_mid: got %0d want 4", cnt4); end
      tick();
      total++; if (cnt4 !== 16'd5) begin bad++; $display("FAIL b2b_cnt: got %0d want 5", cnt4); end
   endtask

   task automatic test_bad_index;
      b3.in_valid_i = 1'b1; b3.in_idx_i = 2'd2; b3.in_data_i = 64'h60; b3.in_last_i = 1'b1;
      tick();
      b3.in_valid_i = 1'b0;
      total++; if (b3.out_valid_o !== 3'b100) begin bad++; $display("FAIL n3_good: got %b want 100", b3.out_valid_o); end
      tick();
      total++; if (cnt3 !== 16'd1) begin bad++; $display("FAIL n3_cnt1: got %0d want 1", cnt3); end
      for (int i = 0; i < 3; i++) begin
         b3.in_valid_i = 1'b1;
         b3.in_idx_i   = (i == 0) ? 2'd3 : 2'd0;
         b3.in_data_i  = 64'h70 + 64'(i);
         b3.in_last_i  = (i == 2);
         #1;
         total++; if (b3.in_ready_o !== 1'b1) begin bad++; $display("FAIL drop_ready[%0d]: got %b want 1", i, b3.in_ready_o); end
         tick();
         total++; if (err3 !== (i == 0)) begin bad++; $display("FAIL drop_err[%0d]: got %b want %b", i, err3, (i == 0)); end
         total++; if (b3.out_valid_o !== 3'b000) begin bad++; $display("FAIL drop_valid[%0d]: got %b want 000", i, b3.out_valid_o); end
      end
      b3.in_valid_i = 1'b0;
      tick();
      total++; if (err3 !== 1'b0 || cnt3 !== 16'd1) begin bad++; $display("FAIL drop_after: got err=%b cnt=%0d want err=0 cnt=1", err3, cnt3); end
      b3.in_valid_i = 1'b1; b3.in_idx_i = 2'd0; b3.in_data_i = 64'h80; b3.in_last_i = 1'b1;
      tick();
      b3.in_valid_i = 1'b0;
      total++; if (b3.out_valid_o !== 3'b001 || b3.out_data_o !== 64'h80) begin bad++; $display("FAIL drop_recover: got %b/%0h want 001/80", b3.out_valid_o, b3.out_data_o); end
      tick();
      total++; if (cnt3 !== 16'd2) begin bad++; $display("FAIL n3_cnt2: got %0d want 2", cnt3); end
   endtask

   task automatic test_reset_mid_packet;
      b4.in_valid_i = 1'b1; b4.in_idx_i = 2'd1; b4.in_data_i = 64'h40; b4.in_last_i = 1'b0;
      tick();
      b4.in_data_i = 64'h41;
      tick();
      total++; if (b4.out_valid_o !== 4'b0010) begin bad++; $display("FAIL mid_busy: got %b want 0010", b4.out_valid_o); end
      b4.in_data_i = 64'h42; b4.in_idx_i = 2'd3;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b4.in_valid_i = 1'b0;
      total++; if (b4.out_valid_o !== 4'b0000) begin bad++; $display("FAIL mid_valid: got %b want 0000", b4.out_valid_o); end
      total++; if (cnt4 !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt4); end
      total++; if (err4 !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err4); end
      b4.in_valid_i = 1'b1; b4.in_idx_i = 2'd3; b4.in_data_i = 64'h50; b4.in_last_i = 1'b1;
      tick();
      b4.in_valid_i = 1'b0;
      total++; if (b4.out_valid_o !== 4'b1000 || b4.out_data_o !== 64'h50) begin bad++; $display("FAIL mid_newpkt: got %b/%0h want 1000/50", b4.out_valid_o, b4.out_data_o); end
      tick();
      total++; if (cnt4 !== 16'd1) begin bad++; $display("FAIL mid_cnt_after: got %0d want 1", cnt4); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      b4.in_valid_i = 1'b0; b4.in_data_i = '0; b4.in_idx_i = '0; b4.in_last_i = 1'b0; b4.out_ready_i = 4'b1111;
      b3.in_valid_i = 1'b0; b3.in_data_i = '0; b3.in_idx_i = '0; b3.in_last_i = 1'b0; b3.out_ready_i = 3'b111;
      test_reset();
      test_single_beat();
      test_locked_dest();
      test_backpressure();
      test_back_to_back();
      test_bad_index();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
